// File: rtl/des_round_ctrl_pkg.sv
// Shared types and the DES key-schedule rotate tables for the round controller.
package des_round_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
  typedef enum logic {DES_ENC = 1'b0, DES_DEC = 1'b1} des_mode_e;

  localparam int DES_ROUNDS = 16;

  // Left-rotate amount applied before each encrypt round; entry 0 is round 0.
  localparam logic [0:15][1:0] ENC_SHIFT = {
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:0] enc_shift(input logic [3:0] idx);
    return ENC_SHIFT[idx];
  endfunction

  // Decrypt walks the encrypt schedule backwards; round 0 uses C16D16 unrotated.
  function automatic logic [1:0] dec_shift(input logic [3:0] idx);
    logic [3:0] j;
    j = 4'(5'd16 - {1'b0, idx});
    return (idx == 4'd0) ? 2'd0 : ENC_SHIFT[j];
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Request/response handshake plus datapath control strobes for the DES round controller.
interface des_round_ctrl_if #(
  parameter int CNT_W = 4
) ();
  logic             in_valid;
  logic             in_mode;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             ld_blk;
  logic             ld_key;
  logic             rnd_en;
  logic [CNT_W-1:0] rnd_idx;
  logic [1:0]       rot_amt;
  logic             rot_dir;
  logic             last_rnd;
  logic             busy;

  modport master (
    output in_valid, in_mode, out_ready,
    input  in_ready, out_valid, ld_blk, ld_key, rnd_en, rnd_idx,
           rot_amt, rot_dir, last_rnd, busy
  );

  modport slave (
    input  in_valid, in_mode, out_ready,
    output in_ready, out_valid, ld_blk, ld_key, rnd_en, rnd_idx,
           rot_amt, rot_dir, last_rnd, busy
  );
endinterface

// File: rtl/des_round_ctrl_shift_sched.sv
// Key-schedule rotate decode: (round index, mode) -> C/D rotate amount and direction.
module des_shift_sched
  import des_round_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] rnd_idx,
  input  des_mode_e        mode,
  output logic [1:0]       rot_amt,
  output logic             rot_dir
);

  logic [3:0] idx4;

  assign idx4    = 4'(rnd_idx);
  assign rot_amt = (mode == DES_DEC) ? dec_shift(idx4) : enc_shift(idx4);
  assign rot_dir = (mode == DES_DEC);

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for the one-round-per-clock DES datapath: load, 16 rounds, hold result.
module des_round_ctrl
  import des_round_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  des_round_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q;
  des_mode_e        mode_q;
  logic             accept;
  logic             last;
  logic [1:0]       sched_amt;

  assign last   = (state_q == ROUND) && (idx_q == CNT_W'(NUM_ROUNDS - 1));
  // DONE forwards out_ready so a waiting request is taken with no bubble.
  assign bus.in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last) state_d = DONE;
      DONE: begin
        if (accept)             state_d = ROUND;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= DES_ENC;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= '0;
        mode_q <= des_mode_e'(bus.in_mode);
      end else if ((state_q == ROUND) && !last) begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

  des_shift_sched #(.CNT_W(CNT_W)) u_sched (
    .rnd_idx (idx_q),
    .mode    (mode_q),
    .rot_amt (sched_amt),
    .rot_dir (bus.rot_dir)
  );

  assign bus.ld_blk    = accept;
  assign bus.ld_key    = accept;
  assign bus.rnd_en    = (state_q == ROUND);
  assign bus.rnd_idx   = idx_q;
  assign bus.rot_amt   = (state_q == ROUND) ? sched_amt : 2'd0;
  assign bus.last_rnd  = last;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Drives des_round_ctrl with a behavioural DES datapath and checks timing plus ciphertext.
module tb_des_round_ctrl;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_round_ctrl_if #(.CNT_W(4)) bus ();
  des_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int rdy_pct = 100;
  int cyc = 0;
  logic [63:0] blk_in, key_in;
  logic [63:0] exp_q[$];
  int hs_q[$];

  int enc_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_t[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int ip_t[64], fp_t[64], e_t[48];
  int p_t[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sb[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // DES bit 1 is the MSB of an inw-bit value held in the low bits of x.
  function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int n, input int kind);
    logic [63:0] o;
    int t;
    o = '0;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: t = ip_t[i];
        1: t = fp_t[i];
        2: t = e_t[i];
        3: t = p_t[i];
        4: t = pc1_t[i];
        default: t = pc2_t[i];
      endcase
      o[n-1-i] = x[inw-t];
    end
    return o;
  endfunction

  function automatic logic [31:0] fbox(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] tmp;
    logic [47:0] e;
    logic [31:0] s;
    logic [5:0]  b;
    tmp = perm({32'b0, r}, 32, 48, 2);
    e = tmp[47:0] ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = e[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(sb[j][int'({b[5], b[0]})*16 + int'(b[4:1])]);
    end
    tmp = perm({32'b0, s}, 32, 32, 3);
    return tmp[31:0];
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] v, input int amt, input logic dir);
    for (int n = 0; n < amt; n++) v = dir ? {v[0], v[27:1]} : {v[26:0], v[27]};
    return v;
  endfunction

  // Textbook DES: all 16 subkeys up front, reversed order for decrypt.
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key, input logic dec);
    logic [47:0] ks[16];
    logic [63:0] tmp;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    tmp = perm(key, 64, 56, 4);
    c = tmp[55:28];
    d = tmp[27:0];
    for (int i = 0; i < 16; i++) begin
      c = rot28(c, enc_t[i], 1'b0);
      d = rot28(d, enc_t[i], 1'b0);
      tmp = perm({8'b0, c, d}, 56, 48, 5);
      ks[i] = tmp[47:0];
    end
    tmp = perm(blk, 64, 64, 0);
    l = tmp[63:32];
    r = tmp[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ fbox(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return perm({r, l}, 64, 64, 1);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: protocol timeline, scoreboard pop, and a register-level datapath driven by the strobes.
  int          phase = 0;
  logic        emode = 1'b0;
  logic        exp_rdy, acc;
  logic [31:0] dp_l, dp_r, fv;
  logic [27:0] dp_c, dp_d, cr, dr;
  logic [63:0] mtmp, outv, expv;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      phase = 0;
    end else begin
      exp_rdy = (phase == 0) || ((phase == NR + 1) && bus.out_ready);
      acc = bus.in_valid && exp_rdy;
      check("ctrl", {bus.in_ready, bus.ld_blk, bus.ld_key, bus.rnd_en, bus.last_rnd, bus.out_valid, bus.busy},
            {exp_rdy, acc, acc, (phase >= 1 && phase <= NR), (phase == NR), (phase == NR + 1), (phase != 0)});
      if (phase >= 1 && phase <= NR)
        check("sched", {bus.rnd_idx, bus.rot_amt, bus.rot_dir},
              {4'(phase - 1), 2'(emode ? dec_t[phase-1] : enc_t[phase-1]), emode});
      if (bus.out_valid && bus.out_ready) begin
        hs_q.push_back(cyc);
        outv = perm({dp_l, dp_r}, 64, 64, 1);
        if (exp_q.size() == 0) check("unexpected_out", outv, 64'hx);
        else begin
          expv = exp_q.pop_front();
          check("dout", outv, expv);
        end
      end
      if (bus.ld_blk) begin
        mtmp = perm(blk_in, 64, 64, 0);
        {dp_l, dp_r} = mtmp;
        mtmp = perm(key_in, 64, 56, 4);
        dp_c = mtmp[55:28];
        dp_d = mtmp[27:0];
      end else if (bus.rnd_en) begin
        cr = rot28(dp_c, int'(bus.rot_amt), bus.rot_dir);
        dr = rot28(dp_d, int'(bus.rot_amt), bus.rot_dir);
        mtmp = perm({8'b0, cr, dr}, 56, 48, 5);
        fv = fbox(dp_r, mtmp[47:0]);
        if (bus.last_rnd) dp_l = dp_l ^ fv;
        else {dp_l, dp_r} = {dp_r, dp_l ^ fv};
        dp_c = cr;
        dp_d = dr;
      end
      if (acc) begin
        phase = 1;
        emode = bus.in_mode;
      end else if (phase >= 1 && phase <= NR) phase++;
      else if (phase == NR + 1 && bus.out_ready) phase = 0;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic send(input logic [63:0] b, input logic [63:0] k, input logic m,
                      input logic [63:0] ev, input bit use_ev);
    bit got;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_mode = m;
    blk_in = b;
    key_in = k;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (got) exp_q.push_back(use_ev ? ev : des_ref(b, k, m));
    else check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus.in_mode = 1'($urandom_range(1));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ip_t[8*r+c] = ((r < 4) ? 58 + 2*r : 57 + 2*(r-4)) - 8*c;
    for (int i = 0; i < 64; i++) fp_t[ip_t[i]-1] = i + 1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++)
        e_t[6*r+c] = ((4*r + c - 1 + 32) % 32) + 1;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    blk_in = '0;
    key_in = '0;

    #3;
    check("reset_out", {bus.in_ready, bus.ld_blk, bus.ld_key, bus.rnd_en, bus.last_rnd,
                        bus.out_valid, bus.busy, bus.rnd_idx, bus.rot_dir}, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Known-answer encrypt then decrypt through the controlled datapath
    rdy_pct = 100;
    send(PT, KEY, 1'b0, CT, 1);
    drain();
    send(CT, KEY, 1'b1, PT, 1);
    drain();

    // Backpressure: output held, in_valid pulses ignored while out_ready is low
    rdy_pct = 0;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0);
    for (int n = 0; n < 40 && !bus.out_valid; n++) @(negedge clk);
    check("outv_seen", bus.out_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1 bus.in_valid = 1'($urandom_range(1));
      blk_in = {$urandom, $urandom};
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rdy_pct = 100;
    drain();

    // Back-to-back: second block accepted in the first DONE cycle
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0);
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 0);
    drain();
    check("b2b_gap", 32'(hs_q[hs_q.size()-1] - hs_q[hs_q.size()-2]), 17);

    // in_mode wiggles while rounds run
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 0);
    idle_cycles(16);
    drain();

    // Reset in round 7 abandons the block
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0);
    for (int n = 0; n < 40 && !(bus.rnd_en && bus.rnd_idx == 4'd7); n++) @(negedge clk);
    check("reach_rnd7", {bus.rnd_en, bus.rnd_idx}, {1'b1, 4'd7});
    #2 rst = 1'b1;
    #1;
    check("midrst_out", {bus.in_ready, bus.ld_blk, bus.rnd_en, bus.last_rnd, bus.out_valid, bus.busy}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    idle_cycles(25);

    // Randomised traffic with random consumer stalls
    repeat (25) begin
      rdy_pct = $urandom_range(100, 30);
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 0, 0);
      idle_cycles($urandom_range(20));
    end
    rdy_pct = 100;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
